// File: rtl/sin_frame_pkg.sv
// Shared definitions for the sine-frame UART transmitter: field widths, byte
// packing, frame FSM encoding and UART line levels.
// Optional build macro: SIN_FRAME_CHECKSUM_EN adds the SEND_CK state.
package sin_frame_pkg;

  localparam int IDX_W   = 12;
  localparam int ID_W    = 4;
  localparam int FRAME_W = IDX_W + ID_W;

  // UART line levels
  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  // Bit slot numbering inside one character: 0 = start, 1..8 = data, 9 = stop
  localparam logic [3:0] LAST_DATA_IDX = 4'd8;
  localparam logic [3:0] STOP_BIT_IDX  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_SEND_B0,
    ST_SEND_B1
`ifdef SIN_FRAME_CHECKSUM_EN
    , ST_SEND_CK
`endif
  } frame_state_t;

  // First line byte carries the board ID and the top nibble of the index
  function automatic logic [7:0] pack_b0(input logic [ID_W-1:0] id,
                                         input logic [IDX_W-1:0] idx);
    return {id, idx[11:8]};
  endfunction

  // Second line byte carries the low byte of the index
  function automatic logic [7:0] pack_b1(input logic [IDX_W-1:0] idx);
    return idx[7:0];
  endfunction

endpackage

// File: rtl/sin_frame_uart_tx_byte.sv
// 8N1 byte serialiser. A one-cycle start launches the start bit on the next
// edge; done pulses in the last cycle of the stop bit so a start issued in that
// same cycle chains the next character with no idle gap.
// The data byte is not latched: the caller keeps it stable until the last data
// bit has been shifted out (it is only sampled from the start-bit's end onward).
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       active
);
  import sin_frame_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic          tx_q;
  logic          active_q;
  logic          last_tick;

  assign last_tick = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign done      = active_q & last_tick & (bit_idx == STOP_BIT_IDX);
  assign tx        = tx_q;
  assign active    = active_q;

  // Baud and bit counters; start has priority so back-to-back chaining works
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      tx_q     <= UART_IDLE;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      tx_q     <= UART_START;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (active_q) begin
      if (last_tick) begin
        baud_cnt <= '0;
        if (bit_idx == STOP_BIT_IDX) begin
          active_q <= 1'b0;
          tx_q     <= UART_IDLE;
          bit_idx  <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx_q    <= (bit_idx == LAST_DATA_IDX) ? UART_STOP : data[bit_idx[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sin_frame_uart_tx.sv
// Frame FIFO + frame FSM feeding the byte serialiser. Each {uart_id, sin_index}
// frame leaves as B0, B1 (and CK = B0 ^ B1 when SIN_FRAME_CHECKSUM_EN is
// defined), characters back to back, frames back to back while work is queued.
// Handshake: data_valid is a one-cycle strobe with no ready; a strobe while the
// FIFO is full and not being popped in the same cycle is dropped and latches
// overflow until reset.
module sin_frame_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_valid,
  input  logic [11:0]                  sin_index,
  input  logic [3:0]                   uart_id,
  output logic                         tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  import sin_frame_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic               overflow_q;
  logic [FRAME_W-1:0] frame_q;

  frame_state_t state;
  frame_state_t next_state;

  logic       pop;
  logic       full;
  logic       wr_en;
  logic       ser_start;
  logic       ser_done;
  logic       ser_active;
  logic [7:0] ser_data;
  logic [7:0] b0;
  logic [7:0] b1;
  logic [7:0] ck;

  assign full  = (level == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en = data_valid & (~full | pop);

  assign b0 = pack_b0(frame_q[FRAME_W-1:IDX_W], frame_q[IDX_W-1:0]);
  assign b1 = pack_b1(frame_q[IDX_W-1:0]);
  assign ck = b0 ^ b1;

  // FIFO storage; a write to the slot being popped sees the old head first
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {uart_id, sin_index};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (data_valid & ~wr_en) overflow_q <= 1'b1;
    end
  end

  // Frame register: head entry captured in POP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else if (pop) begin
      frame_q <= mem[rd_ptr];
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, pop and serialiser start. A SEND state starts its byte only if
  // the serialiser is idle; otherwise the byte was already chained from the
  // previous done pulse (including across a POP between frames).
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    ser_start  = 1'b0;
    ser_data   = b0;
    case (state)
      ST_IDLE: begin
        if (level != '0) next_state = ST_POP;
      end
      ST_POP: begin
        pop        = 1'b1;
        next_state = ST_SEND_B0;
      end
      ST_SEND_B0: begin
        ser_data = b0;
        if (!ser_active) ser_start = 1'b1;
        if (ser_done) begin
          ser_start  = 1'b1;
          next_state = ST_SEND_B1;
        end
      end
      ST_SEND_B1: begin
        ser_data = b1;
        if (!ser_active) ser_start = 1'b1;
        if (ser_done) begin
`ifdef SIN_FRAME_CHECKSUM_EN
          ser_start  = 1'b1;
          next_state = ST_SEND_CK;
`else
          if (level != '0) begin
            ser_start  = 1'b1;
            next_state = ST_POP;
          end else begin
            next_state = ST_IDLE;
          end
`endif
        end
      end
`ifdef SIN_FRAME_CHECKSUM_EN
      ST_SEND_CK: begin
        ser_data = ck;
        if (!ser_active) ser_start = 1'b1;
        if (ser_done) begin
          if (level != '0) begin
            ser_start  = 1'b1;
            next_state = ST_POP;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .reset  (reset),
    .start  (ser_start),
    .data   (ser_data),
    .tx     (tx),
    .done   (ser_done),
    .active (ser_active)
  );

  assign busy       = (state != ST_IDLE) | (level != '0);
  assign overflow   = overflow_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_sin_frame_uart_tx.sv
// Bench for sin_frame_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). Expected line
// bytes go into exp_q as {must_follow_without_gap, byte}; a UART receiver
// process decodes tx and checks each byte against the queue head.
// Follows SIN_FRAME_CHECKSUM_EN to know whether a CK byte is expected.
module tb_sin_frame_uart_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef SIN_FRAME_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int F = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [11:0] sin_index = '0;
  logic [3:0]  uart_id = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_level;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int max_level = 0;

  sin_frame_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst),
    .data_valid (data_valid),
    .sin_index  (sin_index),
    .uart_id    (uart_id),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_frame(input logic [11:0] idx, input logic [3:0] id);
    @(negedge clk);
    data_valid = 1'b1;
    sin_index  = idx;
    uart_id    = id;
  endtask

  task automatic idle_line();
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [11:0] idx, input logic [3:0] id, input logic contig);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = {id, idx[11:8]};
    b1 = idx[7:0];
    exp_q.push_back({contig, b0});
    exp_q.push_back({1'b1, b1});
`ifdef SIN_FRAME_CHECKSUM_EN
    exp_q.push_back({1'b1, b0 ^ b1});
`endif
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk({name, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- fifo level peak tracker ----------------
  always @(negedge clk) begin
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  // ---------------- UART receiver / scoreboard ----------------
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         gap = 1000;
  int         rx_gap = 1000;
  int         k;
  logic [7:0] rx_byte = '0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
      gap     = 1000;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_gap  = gap;
      end else if (gap < 1000) begin
        gap++;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        k = rx_cnt / CPB;
        if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
        if (k == 9) begin
          chk("rx_stop_bit", 32'(tx), 32'd1);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rx_byte: got 0x%0h expected no byte", rx_byte);
          end else begin
            e = exp_q.pop_front();
            if (rx_byte !== e[7:0]) begin
              n_bad++;
              $display("FAIL rx_byte: got 0x%0h expected 0x%0h", rx_byte, e[7:0]);
            end
            if (e[8]) chk("rx_gap", 32'(rx_gap), 32'd0);
          end
        end
      end
      if (rx_cnt == 10 * CPB - 1) begin
        rx_busy = 1'b0;
        gap     = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single frame 0x5A3/0x7 -> 0x75, 0xA3 (+0xD6 with checksum)
    push_frame(12'h5A3, 4'h7, 1'b0);
    drive_frame(12'h5A3, 4'h7);
    idle_line();
    chk("t1_busy_on", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_tx_before_start", 32'(tx), 32'd1);
    @(negedge clk);
    chk("t1_start_bit", 32'(tx), 32'd0);
    c = 0;
    while (busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("t1_busy_len", 32'(c), 32'(F));
    wait_idle("t1");

    // back-to-back frames with no idle gap
    push_frame(12'h000, 4'h0, 1'b0);
    push_frame(12'h800, 4'h8, 1'b1);
    drive_frame(12'h000, 4'h0);
    drive_frame(12'h800, 4'h8);
    idle_line();
    wait_idle("t6");
    chk("t6_overflow", 32'(overflow), 32'd0);

    // six consecutive strobes: five sent, sixth dropped
    max_level = 0;
    for (int i = 1; i <= 5; i++) push_frame(12'(i), 4'h1, (i != 1));
    for (int i = 1; i <= 6; i++) drive_frame(12'(i), 4'h1);
    idle_line();
    chk("t3_level_full", 32'(fifo_level), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    wait_idle("t3");
    chk("t3_level_peak", 32'(max_level), 32'd4);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_overflow_cleared", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full FIFO and strobe coincident with POP -> accepted
    for (int i = 0; i < 6; i++) push_frame(12'h010 + 12'(i), 4'h2, (i != 0));
    for (int i = 0; i < 5; i++) drive_frame(12'h010 + 12'(i), 4'h2);
    idle_line();
    repeat (F - 2) @(negedge clk);
    chk("t4_level_before", 32'(fifo_level), 32'd4);
    drive_frame(12'h015, 4'h2);
    idle_line();
    chk("t4_level_after", 32'(fifo_level), 32'd4);
    chk("t4_overflow", 32'(overflow), 32'd0);
    wait_idle("t4");
    chk("t4_overflow_end", 32'(overflow), 32'd0);

    // reset during B1 data bit 3, then a clean frame
    push_frame(12'h5A3, 4'h7, 1'b0);
    push_frame(12'h234, 4'h1, 1'b1);
    drive_frame(12'h5A3, 4'h7);
    drive_frame(12'h234, 4'h1);
    idle_line();
    repeat (59) @(posedge clk);
    #1;
    chk("t5_bit3_low", 32'(tx), 32'd0);
    chk("t5_level_queued", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_tx_async", 32'(tx), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_tx_idle", 32'(tx), 32'd1);
    push_frame(12'hFFF, 4'hF, 1'b0);
    drive_frame(12'hFFF, 4'hF);
    idle_line();
    wait_idle("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
